alu_mdu: RTL and testbench

- Iterative multiply/divide unit implementing RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), generalised to WIDTH bits.
- Sits in EX beside the combinational ALU; the pipeline stalls on in_ready=0 / out_valid=0.
- Valid/ready handshakes on both sides.
- Fast path for divide-by-zero and signed overflow.
- Flush kills an in-flight operation, for branch mispredict recovery.

---
 rtl/alu_mdu.sv | 104 ++++++++++
 tb/tb_alu_mdu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: iterative RV32M-style multiply/divide unit with valid/ready handshakes
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       md_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, m;
    logic [2:0] op;
    logic sa, sb;
    logic a_signed, b_signed, sa_in, sb_in, div_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, fast_res;
    logic [WIDTH:0] sum, sh;
    logic ge;
    logic [WIDTH-1:0] hi_n, lo_n, q_s, r_s, fin;
    logic [2*WIDTH-1:0] prod, prod_s;

    // Operand decode at accept: signedness, magnitudes and fast-path results
    always_comb begin
        a_signed = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
        b_signed = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
        sa_in = a_signed & operand_a[WIDTH-1];
        sb_in = b_signed & operand_b[WIDTH-1];
        a_mag = sa_in ? -operand_a : operand_a;
        b_mag = sb_in ? -operand_b : operand_b;
        div_zero = md_op[2] && (operand_b == '0);
        ovf = md_op[2] && !md_op[0] && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b);
        fast_res = div_zero ? (md_op[1] ? operand_a : '1) : (md_op[1] ? '0 : operand_a);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        sh = {hi, lo[WIDTH-1]};
        ge = sh >= {1'b0, m};
        hi_n = op[2] ? (ge ? sh[WIDTH-1:0] - m : sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n = op[2] ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
        prod = {hi_n, lo_n};
        prod_s = (sa ^ sb) ? -prod : prod;
        q_s = (sa ^ sb) ? -lo_n : lo_n;
        r_s = sa ? -hi_n : hi_n;
        fin = op[2] ? (op[1] ? r_s : q_s) : (op == 3'd0 ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    op    <= md_op;
                    sa    <= sa_in;
                    sb    <= sb_in;
                    hi    <= '0;
                    lo    <= md_op[2] ? a_mag : b_mag;
                    m     <= md_op[2] ? b_mag : a_mag;
                    cnt   <= CNT_W'(WIDTH - 1);
                    state <= (div_zero || ovf) ? DONE : CALC;
                    if (div_zero || ovf) result <= fast_res;
                end
                CALC: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= fin;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = !in_ready;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table-driven check of alu_mdu plus handshake/flush/reset sequences
module tb_alu_mdu;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, busy;
    logic [31:0] operand_a = '0, operand_b = '0, result;
    logic [2:0] md_op = '0;
    int checks = 0, failures = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .md_op(md_op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the accept edge; waits for out_valid
    task automatic wait_done(input int exp_lat, input logic [31:0] exp_res, input string name);
        int lat = 1;
        logic ir_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, result, exp_res);
        chk({name, " in_ready low"}, {31'd0, ir_low & !in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        operand_a = v.a;
        operand_b = v.b;
        md_op = v.op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        operand_a = ~v.a;
        operand_b = v.a;
        md_op = ~v.op;
        wait_done(v.lat, v.exp, v.name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({v.name, " back to idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    vec_t vecs[19] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "MUL 7*-3"},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "MULH min*min"},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "MULHU max*max"},
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "MULHSU -1*max"},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "DIV -7/2"},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "REM -7/2"},
        '{3'd5, 32'd100,      32'd7,        32'd14,       33, "DIVU 100/7"},
        '{3'd7, 32'd100,      32'd7,        32'd2,        33, "REMU 100/7"},
        '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "DIVU 5/0"},
        '{3'd6, 32'd5,        32'd0,        32'd5,        1,  "REM 5/0"},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "DIV ovf"},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "REM ovf"},
        '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "DIV 5/0"},
        '{3'd7, 32'd5,        32'd0,        32'd5,        1,  "REMU 5/0"},
        '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 33, "MUL shift"},
        '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 33, "MULH -3*5"},
        '{3'd3, 32'h80000000, 32'h00000002, 32'h00000001, 33, "MULHU carry"},
        '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "DIV 7/-2"},
        '{3'd4, 32'h80000000, 32'h00000001, 32'h80000000, 33, "DIV min/1"}
    };

    initial begin
        #2;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: result must hold while out_ready is low, in_valid ignored
        @(negedge clk);
        operand_a = 32'd100; operand_b = 32'd7; md_op = 3'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(33, 32'd14, "bp DIVU");
        operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF; md_op = 3'd3; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold result", result, 32'd14);
            chk("bp hold valid", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp no same-cycle accept", {30'd0, in_ready, out_valid}, 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp accepted next cycle", {31'd0, in_ready}, 32'd0);
        operand_a = '0; md_op = 3'd0;
        wait_done(33, 32'hFFFFFFFE, "bp MULHU");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush at CALC cycle 12 with a competing in_valid
        @(negedge clk);
        operand_a = 32'd7; operand_b = 32'hFFFFFFFD; md_op = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("flush busy before", {31'd0, busy}, 32'd1);
        operand_a = 32'd5; operand_b = 32'd0; md_op = 3'd5; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush idle", {29'd0, in_ready, out_valid, busy}, 32'd4);
        chk("flush result kept", result, 32'hFFFFFFFE);
        begin
            logic saw = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid || !in_ready) saw = 1'b1;
            end
            chk("flush no output", {31'd0, saw}, 32'd0);
        end

        // Async reset mid-CALC
        @(negedge clk);
        operand_a = 32'd100; operand_b = 32'd7; md_op = 3'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        chk("rst mid result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
